// File: rtl/controle_execucao.sv
// RV32I single-cycle control: instruction decode plus a run/halt/step sequencer
// that owns commit permission (PC, register file, memory) and the harness counters.
module controle_execucao #(
  parameter int CNT_W       = 32,
  parameter int WDOG_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  output logic             PCWrite,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic [1:0]       ResultSrc,
  output logic [3:0]       ALUControl,
  output logic [2:0]       state,
  output logic [1:0]       trap_cause,
  output logic             busy,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] instret
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_HALT = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_TRAP = 3'd4;

  localparam logic [CNT_W-1:0] WDOG_LIM = CNT_W'(WDOG_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic legal, is_ebreak, dec_reg_w, dec_mem_w;
  logic step_q, step_edge, wdog_exp, exec;

  always_comb begin
    legal      = 1'b0;
    is_ebreak  = 1'b0;
    dec_reg_w  = 1'b0;
    dec_mem_w  = 1'b0;
    ALUSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUControl = 4'b0000;
    case (opcode)
      7'b0110011: if (funct3 == 3'b000) begin
        if (funct7 == 7'b0000000) begin
          legal = 1'b1; dec_reg_w = 1'b1;
        end else if (funct7 == 7'b0100000) begin
          legal = 1'b1; dec_reg_w = 1'b1; ALUControl = 4'b0001;
        end
      end
      7'b0010011: if (funct3 == 3'b000) begin
        legal = 1'b1; dec_reg_w = 1'b1; ALUSrc = 1'b1;
      end
      7'b0000011: if (funct3 == 3'b010) begin
        legal = 1'b1; dec_reg_w = 1'b1; ALUSrc = 1'b1; ResultSrc = 2'b01;
      end
      7'b0100011: if (funct3 == 3'b010) begin
        legal = 1'b1; dec_mem_w = 1'b1; ALUSrc = 1'b1;
      end
      7'b1110011: if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
        legal = 1'b1; is_ebreak = 1'b1;
      end
      default: ;
    endcase
  end

  assign step_edge = step_req & ~step_q;
  assign wdog_exp  = (WDOG_CYCLES != 0) && (cycles == WDOG_LIM);
  assign busy      = (state == S_RUN);

  // Commit only for real work; ebreak/illegal never touch architectural state.
  assign exec = legal & ~is_ebreak &
                (((state == S_RUN) & ~halt_req & ~wdog_exp) |
                 ((state == S_HALT) & step_edge));

  assign PCWrite  = exec;
  assign RegWrite = exec & dec_reg_w;
  assign MemWrite = exec & dec_mem_w;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      trap_cause <= 2'd0;
      cycles     <= '0;
      instret    <= '0;
      step_q     <= 1'b0;
    end else begin
      step_q <= step_req;
      // The expiry cycle is not counted so cycles freezes at the limit.
      if (state == S_RUN && !wdog_exp && cycles != CNT_MAX)
        cycles <= cycles + 1'b1;
      if (exec && instret != CNT_MAX)
        instret <= instret + 1'b1;
      case (state)
        S_IDLE: if (start) state <= S_RUN;
        S_RUN: begin
          if (wdog_exp) begin
            state <= S_TRAP; trap_cause <= 2'd2;
          end else if (!legal) begin
            state <= S_TRAP; trap_cause <= 2'd1;
          end else if (is_ebreak) begin
            state <= S_DONE;
          end else if (halt_req) begin
            state <= S_HALT;
          end
        end
        S_HALT: begin
          if (start) begin
            state <= S_RUN;
          end else if (step_edge) begin
            if (!legal) begin
              state <= S_TRAP; trap_cause <= 2'd1;
            end else if (is_ebreak) begin
              state <= S_DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controle_execucao.sv
// Directed bench for controle_execucao: program run, traps, halt/step, watchdog, reset.
module tb_controle_execucao;

  logic clk = 1'b0;
  logic reset_n, start, halt_req, step_req;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;

  logic PCWrite, MemWrite, RegWrite, ALUSrc, busy;
  logic [1:0] ResultSrc, trap_cause;
  logic [3:0] ALUControl;
  logic [2:0] state;
  logic [31:0] cycles, instret;

  logic w_PCWrite, w_MemWrite, w_RegWrite, w_ALUSrc, w_busy;
  logic [1:0] w_ResultSrc, w_trap_cause;
  logic [3:0] w_ALUControl;
  logic [2:0] w_state;
  logic [31:0] w_cycles, w_instret;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  controle_execucao #(.CNT_W(32), .WDOG_CYCLES(0)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .halt_req(halt_req),
    .step_req(step_req), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .ALUSrc(ALUSrc), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
    .state(state), .trap_cause(trap_cause), .busy(busy),
    .cycles(cycles), .instret(instret)
  );

  controle_execucao #(.CNT_W(32), .WDOG_CYCLES(4)) u_wd (
    .clk(clk), .reset_n(reset_n), .start(start), .halt_req(halt_req),
    .step_req(step_req), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .PCWrite(w_PCWrite), .MemWrite(w_MemWrite), .RegWrite(w_RegWrite),
    .ALUSrc(w_ALUSrc), .ResultSrc(w_ResultSrc), .ALUControl(w_ALUControl),
    .state(w_state), .trap_cause(w_trap_cause), .busy(w_busy),
    .cycles(w_cycles), .instret(w_instret)
  );

  localparam logic [31:0] I_ADDI1 = 32'h00500093;
  localparam logic [31:0] I_ADDI2 = 32'h00A00113;
  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_SW    = 32'h00302623;
  localparam logic [31:0] I_LW    = 32'h00C02203;
  localparam logic [31:0] I_EBRK  = 32'h00100073;
  localparam logic [31:0] I_SUB   = 32'h402081B3;
  localparam logic [31:0] I_ZERO  = 32'h00000000;

  task automatic set_instr(input logic [31:0] ins);
    opcode = ins[6:0];
    funct3 = ins[14:12];
    funct7 = ins[31:25];
  endtask

  // Advance past the next rising edge; inputs change 2 ns after it.
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset_n = 1'b0; start = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    set_instr(I_ADDI1);
    #3;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset_n = 1'b0;
    set_instr(I_ADDI1);
    #1;
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    total++; if (trap_cause !== 2'd0) begin bad++; $display("FAIL reset_cause got=%0d exp=0", trap_cause); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (cycles !== 32'd0 || instret !== 32'd0) begin bad++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", cycles, instret); end
    total++; if ({PCWrite, RegWrite, MemWrite} !== 3'b000) begin bad++; $display("FAIL reset_enables got=%b exp=000", {PCWrite, RegWrite, MemWrite}); end
    total++; if (ALUSrc !== 1'b1) begin bad++; $display("FAIL reset_decode got=%0b exp=1", ALUSrc); end
    set_instr(I_SUB);
    #1;
    total++; if (ALUControl !== 4'b0001) begin bad++; $display("FAIL reset_decode_sub got=%b exp=0001", ALUControl); end
    reset_n = 1'b1;
  endtask

  task automatic test_program;
    logic [31:0] prog [6];
    logic [4:0]  exp_en [6];   // {ALUSrc, RS[1:0], MemWrite, RegWrite}
    prog = '{I_ADDI1, I_ADDI2, I_ADD, I_SW, I_LW, I_EBRK};
    exp_en = '{5'b1_00_01, 5'b1_00_01, 5'b0_00_01, 5'b1_00_10, 5'b1_01_01, 5'b0_00_00};
    do_reset();
    do_start();
    total++; if (state !== 3'd1 || busy !== 1'b1) begin bad++; $display("FAIL start_run got=%0d/%0b exp=1/1", state, busy); end
    for (int i = 0; i < 6; i++) begin
      set_instr(prog[i]);
      #1;
      total++;
      if ({ALUSrc, ResultSrc, MemWrite, RegWrite} !== exp_en[i] || PCWrite !== (i < 5)) begin
        bad++;
        $display("FAIL prog_step%0d got=%b pc=%0b exp=%b pc=%0b", i,
                 {ALUSrc, ResultSrc, MemWrite, RegWrite}, PCWrite, exp_en[i], (i < 5));
      end
      tick();
    end
    total++; if (state !== 3'd3) begin bad++; $display("FAIL prog_done got=%0d exp=3", state); end
    total++; if (instret !== 32'd5 || cycles !== 32'd6) begin bad++; $display("FAIL prog_counts got=%0d/%0d exp=5/6", instret, cycles); end
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (state !== 3'd3 || cycles !== 32'd6) begin bad++; $display("FAIL done_sticky got=%0d/%0d exp=3/6", state, cycles); end
  endtask

  task automatic test_illegal;
    do_reset();
    do_start();
    set_instr(I_ADDI1);
    tick();
    set_instr(I_ZERO);
    #1;
    total++; if ({PCWrite, RegWrite, MemWrite} !== 3'b000 || ALUSrc !== 1'b0) begin bad++; $display("FAIL illegal_enables got=%b/%0b exp=000/0", {PCWrite, RegWrite, MemWrite}, ALUSrc); end
    tick();
    total++; if (state !== 3'd4 || trap_cause !== 2'd1) begin bad++; $display("FAIL illegal_trap got=%0d/%0d exp=4/1", state, trap_cause); end
    total++; if (instret !== 32'd1) begin bad++; $display("FAIL illegal_instret got=%0d exp=1", instret); end
    start = 1'b1;
    set_instr(I_ADDI1);
    tick();
    start = 1'b0;
    #1;
    total++; if (state !== 3'd4 || PCWrite !== 1'b0) begin bad++; $display("FAIL trap_sticky got=%0d/%0b exp=4/0", state, PCWrite); end
  endtask

  task automatic test_halt_step;
    do_reset();
    do_start();
    set_instr(I_ADDI1);
    tick();
    set_instr(I_ADDI2);
    halt_req = 1'b1;
    #1;
    total++; if (PCWrite !== 1'b0 || RegWrite !== 1'b0) begin bad++; $display("FAIL halt_gate got=%0b%0b exp=00", PCWrite, RegWrite); end
    tick();
    halt_req = 1'b0;
    #1;
    total++; if (state !== 3'd2 || instret !== 32'd1 || PCWrite !== 1'b0) begin bad++; $display("FAIL halt_state got=%0d/%0d/%0b exp=2/1/0", state, instret, PCWrite); end
    step_req = 1'b1;
    #1;
    total++; if (PCWrite !== 1'b1 || RegWrite !== 1'b1) begin bad++; $display("FAIL step_commit got=%0b%0b exp=11", PCWrite, RegWrite); end
    for (int k = 0; k < 3; k++) tick();
    #1;
    total++; if (instret !== 32'd2 || state !== 3'd2 || PCWrite !== 1'b0) begin bad++; $display("FAIL step_once got=%0d/%0d/%0b exp=2/2/0", instret, state, PCWrite); end
    step_req = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (state !== 3'd1) begin bad++; $display("FAIL resume got=%0d exp=1", state); end
    // A step landing on ebreak finishes the program.
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    tick();
    set_instr(I_EBRK);
    step_req = 1'b1;
    #1;
    total++; if (PCWrite !== 1'b0) begin bad++; $display("FAIL step_ebreak_gate got=%0b exp=0", PCWrite); end
    tick();
    step_req = 1'b0;
    total++; if (state !== 3'd3 || instret !== 32'd2) begin bad++; $display("FAIL step_ebreak got=%0d/%0d exp=3/2", state, instret); end
  endtask

  task automatic test_halt_illegal;
    do_reset();
    do_start();
    halt_req = 1'b1;
    set_instr(I_ZERO);
    tick();
    halt_req = 1'b0;
    total++; if (state !== 3'd4 || trap_cause !== 2'd1) begin bad++; $display("FAIL halt_vs_illegal got=%0d/%0d exp=4/1", state, trap_cause); end
  endtask

  task automatic test_watchdog;
    do_reset();
    set_instr(I_ADDI1);
    do_start();
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (w_PCWrite !== 1'b1) begin bad++; $display("FAIL wdog_run%0d got=%0b exp=1", i, w_PCWrite); end
      tick();
    end
    #1;
    total++; if ({w_PCWrite, w_RegWrite, w_MemWrite} !== 3'b000) begin bad++; $display("FAIL wdog_expiry got=%b exp=000", {w_PCWrite, w_RegWrite, w_MemWrite}); end
    tick();
    tick();
    total++; if (w_state !== 3'd4 || w_trap_cause !== 2'd2) begin bad++; $display("FAIL wdog_trap got=%0d/%0d exp=4/2", w_state, w_trap_cause); end
    total++; if (w_instret !== 32'd4 || w_cycles !== 32'd4) begin bad++; $display("FAIL wdog_counts got=%0d/%0d exp=4/4", w_instret, w_cycles); end
    total++; if (state !== 3'd1 || instret !== 32'd6) begin bad++; $display("FAIL nowdog_run got=%0d/%0d exp=1/6", state, instret); end
  endtask

  task automatic test_reset_midrun;
    do_reset();
    do_start();
    set_instr(I_SW);
    tick();
    tick();
    #1;
    total++; if (MemWrite !== 1'b1 || instret !== 32'd2) begin bad++; $display("FAIL pre_reset got=%0b/%0d exp=1/2", MemWrite, instret); end
    reset_n = 1'b0;
    #1;
    total++; if ({PCWrite, RegWrite, MemWrite} !== 3'b000) begin bad++; $display("FAIL midrun_enables got=%b exp=000", {PCWrite, RegWrite, MemWrite}); end
    total++; if (state !== 3'd0 || cycles !== 32'd0 || instret !== 32'd0) begin bad++; $display("FAIL midrun_state got=%0d/%0d/%0d exp=0/0/0", state, cycles, instret); end
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    set_instr(I_ZERO);
    test_reset();
    test_program();
    test_illegal();
    test_halt_step();
    test_halt_illegal();
    test_watchdog();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
